instr_sequencer: RTL

//  Multi-cycle instruction sequencer for the phase-1 CPU core.
//  - Owns the PC and instruction register (IR).
//  - Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshaking with instr and data memory.
//  - Issues per-phase strobes to the ALU and register file.
//  - Qualifies the level control bits from the combinational opcode decoder, which is fed from ir[31:26].

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/seq_perf_counters.sv | 38 +++
 rtl/instr_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the phase-1 CPU core.
//   seq_state_t : instruction sequencer states
//   OPC_*       : opcode field values (ir[OPC_MSB:OPC_LSB])
//   INSTR_W     : instruction word width
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  localparam logic [5:0] OPC_ADD  = 6'h00;
  localparam logic [5:0] OPC_SUB  = 6'h01;
  localparam logic [5:0] OPC_AND  = 6'h02;
  localparam logic [5:0] OPC_HALT = 6'b111111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } seq_state_t;

endpackage

// File: rtl/seq_perf_counters.sv
// Free-running performance counters for the instruction sequencer.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   busy        : count one cycle per clock while high
//   retire      : count one instruction per clock while high
//   cycle_cnt   : 32-bit busy-cycle count, wraps
//   retire_cnt  : 32-bit retired-instruction count, wraps
module seq_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        busy,
  input  logic        retire,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt
);

  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    cycle_cnt_d  = cycle_cnt_q + {31'd0, busy};
    retire_cnt_d = retire_cnt_q + {31'd0, retire};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: owns PC and IR and steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB.
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   run                             : level, allow fetching new instructions
//   imem_req/addr/ack/rdata         : instruction fetch handshake
//   ir, pc                          : instruction register, program counter
//   cu_mem_read/write, cu_reg_write : level controls from the opcode decoder
//   alu_load                        : EXEC pulse, latch ALU result
//   dmem_req/we/ack                 : data memory handshake
//   rf_we, retire                   : WB strobes
//   busy, halted                    : status
//   cycle_cnt, retire_cnt           : perf counters
// Build option: define SEQ_PERF_CNT_EN to enable the perf counters;
// otherwise both counter outputs are tied to zero.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    pc,
  input  logic               cu_mem_read,
  input  logic               cu_mem_write,
  input  logic               cu_reg_write,
  output logic               alu_load,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic               rf_we,
  output logic               retire,
  output logic               busy,
  output logic               halted,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        retire_cnt
);

  localparam logic [PC_W-1:0] PC_INC = PC_W'(PC_STEP);

  seq_state_t         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      IDLE:   if (run) state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: state_d = (ir_q[OPC_MSB:OPC_LSB] == OPC_HALT) ? HALT : EXEC;
      EXEC:   state_d = (cu_mem_read || cu_mem_write) ? MEM : WB;
      MEM:    if (dmem_ack) state_d = WB;
      WB: begin
        pc_d    = pc_q + PC_INC;  // wraps mod 2^PC_W
        state_d = run ? FETCH : IDLE;
      end
      HALT:   state_d = HALT;     // only rst leaves HALT
      default: state_d = IDLE;
    endcase
  end

  // Outputs are pure decodes of the state register, so no ack can
  // combinationally reach a req, and reset drops every strobe at once.
  always_comb begin
    imem_req = (state_q == FETCH);
    alu_load = (state_q == EXEC);
    dmem_req = (state_q == MEM);
    // A read+write decode is treated as a write.
    dmem_we  = (state_q == MEM) && cu_mem_write;
    rf_we    = (state_q == WB) && cu_reg_write;
    retire   = (state_q == WB);
    busy     = (state_q != IDLE) && (state_q != HALT);
    // HALT is absorbing, so the state decode is already sticky.
    halted   = (state_q == HALT);
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;

`ifdef SEQ_PERF_CNT_EN
  seq_perf_counters u_perf (
    .clk        (clk),
    .rst        (rst),
    .busy       (busy),
    .retire     (retire),
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt)
  );
`else
  assign cycle_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule
